fetch_prefetch_buffer: RTL and testbench

//  Instruction fetch front-end between instruction memory and decode.
//  - Issues sequential word fetches to a pipelined instruction memory.
//  - Queues returned words with their PCs in a DEPTH-entry FIFO.
//  - Hands {pc, instruction} to decode over a valid/ready handshake.
//  - On a branch/jump redirect: flushes the FIFO and discards in-flight responses.

---
 rtl/fetch_prefetch_buffer.sv | 121 ++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch front-end: issues sequential word fetches under a credit limit,
// queues {pc, instruction} for decode, and flushes/discards in-flight work on redirect.
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [CW:0]      in_use;
  logic             credit_ok;
  logic             accept;
  logic             rsp_discard;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_target;
  logic [CW-1:0]    in_flight_after_rsp;
  logic [CW-1:0]    outstanding_next;
  logic [CW-1:0]    count_next;
  logic [DEPTH-1:0] wr_en;

  // Entries held plus requests in flight never exceed DEPTH, so every
  // response is guaranteed a FIFO slot and memory never needs backpressure.
  assign in_use    = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign credit_ok = in_use < (CW + 1)'(DEPTH);

  assign imem_req_valid = reset & ~redirect_valid & credit_ok;
  assign imem_req_addr  = fetch_pc_reg;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rsp_discard = redirect_valid | (drop_reg != '0);
  assign push        = imem_rsp_valid & ~rsp_discard;

  assign ins_valid = reset & (count_reg != '0) & ~redirect_valid;
  assign pop       = ins_valid & ins_ready;
  assign ins_data  = reset ? data_mem[rd_ptr_reg] : '0;
  assign ins_pc    = reset ? pc_mem[rd_ptr_reg]   : '0;

  assign redirect_target     = redirect_pc & ~32'h3;
  assign in_flight_after_rsp = outstanding_reg - CW'(imem_rsp_valid);
  assign outstanding_next    = in_flight_after_rsp + CW'(accept);
  assign count_next          = count_reg + CW'(push) - CW'(pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push & (wr_ptr_reg == AW'(gi));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path; a response landing
      // this very cycle is already discarded, so it is not counted again.
      fetch_pc_reg    <= redirect_target;
      rsp_pc_reg      <= redirect_target;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= in_flight_after_rsp;
      drop_reg        <= in_flight_after_rsp;
    end else begin
      if (accept) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (push) begin
        rsp_pc_reg <= rsp_pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (imem_rsp_valid && (drop_reg != '0)) begin
        drop_reg <= drop_reg - CW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      outstanding_reg <= outstanding_next;
      count_reg       <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          pc_mem[i]   <= rsp_pc_reg;
          data_mem[i] <= imem_rsp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: hand-derived vector table, a long-latency redirect
// sequence, and randomized traffic checked against a queue-based reference model.
module tb_fetch_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ins_valid(ins_valid),
    .ins_ready(ins_ready),
    .ins_data(ins_data),
    .ins_pc(ins_pc)
  );

  always #5 clk = ~clk;

  // Memory stand-in: in-order pipelined responses, per-request latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    last_due = 0;
  int    cyc = 0;

  // Reference model: the architectural state as plain queues and counters.
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_rsp = RESET_PC;
  logic [31:0] m_fifo[$];
  int          m_inflight = 0;
  int          m_drop = 0;

  int errors = 0;
  int checks = 0;

  logic        s_rv;
  logic        s_iv;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_data;

  typedef struct {
    bit          rst;
    bit          ir;
    bit          redir;
    logic [31:0] rpc;
    bit          erv;
    logic [31:0] eaddr;
    bit          eiv;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit ir, input bit redir, input logic [31:0] rpc,
                     input bit erv, input logic [31:0] eaddr, input bit eiv, input logic [31:0] epc);
    tbl.push_back('{rst, ir, redir, rpc, erv, eaddr, eiv, epc});
  endtask

  // One clock: drive inputs after the falling edge, sample, check against the model,
  // let memory capture an accepted request, then advance the model.
  task automatic step(input bit rst, input bit rdy, input bit ir, input bit redir,
                      input logic [31:0] rpc, input int lat);
    bit erv;
    bit eiv;
    int d;
    @(negedge clk);
    reset          = rst;
    imem_req_ready = rdy;
    ins_ready      = ir;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst) begin
      mq.delete();
      last_due = 0;
    end else if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    s_rv   = imem_req_valid;
    s_addr = imem_req_addr;
    s_iv   = ins_valid;
    s_pc   = ins_pc;
    s_data = ins_data;

    erv = rst && !redir && (m_fifo.size() + m_inflight < DEPTH);
    eiv = rst && !redir && (m_fifo.size() != 0);
    check("req_valid", {31'b0, s_rv}, {31'b0, erv});
    if (erv) check("req_addr", s_addr, m_fetch);
    check("ins_valid", {31'b0, s_iv}, {31'b0, eiv});
    if (eiv) begin
      check("ins_pc", s_pc, m_fifo[0]);
      check("ins_data", s_data, memf(m_fifo[0]));
    end

    if (rst && s_rv && rdy) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      mq.push_back('{s_addr, d});
      last_due = d;
    end

    if (!rst) begin
      m_fetch    = RESET_PC;
      m_rsp      = RESET_PC;
      m_fifo.delete();
      m_inflight = 0;
      m_drop     = 0;
    end else if (redir) begin
      if (imem_rsp_valid) m_inflight--;
      m_fifo.delete();
      m_drop  = m_inflight;
      m_fetch = {rpc[31:2], 2'b00};
      m_rsp   = m_fetch;
    end else begin
      if (eiv && ir) void'(m_fifo.pop_front());
      if (imem_rsp_valid) begin
        m_inflight--;
        if (m_drop > 0) m_drop--;
        else begin
          m_fifo.push_back(m_rsp);
          m_rsp = m_rsp + 32'd4;
        end
      end
      if (erv && rdy) begin
        m_fetch = m_fetch + 32'd4;
        m_inflight++;
      end
    end
    cyc++;
  endtask

  initial begin
    bit          seen;
    bit          rst;
    bit          redir;
    logic [31:0] rpc;

    // rst ir redir rpc | req_valid addr | ins_valid pc   (1-cycle memory, always ready)
    add(0, 1, 0, 0,            0, 0,            0, 0);
    add(1, 1, 0, 0,            1, 32'h0,        0, 0);
    add(1, 1, 0, 0,            1, 32'h4,        0, 0);
    add(1, 1, 0, 0,            1, 32'h8,        1, 32'h0);
    add(1, 1, 0, 0,            1, 32'hC,        1, 32'h4);
    add(1, 1, 0, 0,            1, 32'h10,       1, 32'h8);
    add(1, 0, 0, 0,            1, 32'h14,       1, 32'hC);
    add(1, 0, 0, 0,            1, 32'h18,       1, 32'hC);
    add(1, 0, 0, 0,            0, 0,            1, 32'hC);
    add(1, 0, 0, 0,            0, 0,            1, 32'hC);
    add(1, 0, 0, 0,            0, 0,            1, 32'hC);
    add(1, 1, 0, 0,            0, 0,            1, 32'hC);
    add(1, 1, 0, 0,            1, 32'h1C,       1, 32'h10);
    add(1, 1, 0, 0,            1, 32'h20,       1, 32'h14);
    add(1, 1, 0, 0,            1, 32'h24,       1, 32'h18);
    add(1, 1, 0, 0,            1, 32'h28,       1, 32'h1C);
    add(1, 1, 1, 32'h200,      0, 0,            0, 0);
    add(1, 1, 0, 0,            1, 32'h200,      0, 0);
    add(1, 1, 0, 0,            1, 32'h204,      0, 0);
    add(1, 1, 0, 0,            1, 32'h208,      1, 32'h200);
    add(1, 1, 1, 32'hFFFFFFFE, 0, 0,            0, 0);
    add(1, 1, 0, 0,            1, 32'hFFFFFFFC, 0, 0);
    add(1, 1, 0, 0,            1, 32'h0,        0, 0);
    add(1, 1, 0, 0,            1, 32'h4,        1, 32'hFFFFFFFC);
    add(1, 1, 0, 0,            1, 32'h8,        1, 32'h0);
    add(1, 0, 0, 0,            1, 32'hC,        1, 32'h4);
    add(1, 0, 0, 0,            1, 32'h10,       1, 32'h4);
    add(1, 0, 0, 0,            0, 0,            1, 32'h4);
    add(1, 0, 0, 0,            0, 0,            1, 32'h4);
    add(0, 1, 0, 0,            0, 0,            0, 0);
    add(1, 1, 0, 0,            1, RESET_PC,     0, 0);
    add(1, 1, 0, 0,            1, 32'h4,        0, 0);
    add(1, 1, 0, 0,            1, 32'h8,        1, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, 1'b1, tbl[i].ir, tbl[i].redir, tbl[i].rpc, 1);
      $display("vec %0d: req_valid=%0b addr=%h ins_valid=%0b pc=%h", i, s_rv, s_addr, s_iv, s_pc);
      check($sformatf("vec%0d_req_valid", i), {31'b0, s_rv}, {31'b0, tbl[i].erv});
      if (tbl[i].erv) check($sformatf("vec%0d_req_addr", i), s_addr, tbl[i].eaddr);
      check($sformatf("vec%0d_ins_valid", i), {31'b0, s_iv}, {31'b0, tbl[i].eiv});
      if (tbl[i].eiv) check($sformatf("vec%0d_ins_pc", i), s_pc, tbl[i].epc);
      if (!tbl[i].rst) begin
        check($sformatf("vec%0d_rst_ins_pc", i), s_pc, 32'h0);
        check($sformatf("vec%0d_rst_ins_data", i), s_data, 32'h0);
      end
    end

    // Redirect with three requests in flight on a 4-cycle memory.
    step(0, 1, 1, 0, 0, 4);
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 0, 4);
    step(1, 1, 1, 1, 32'h103, 4);
    $display("redirect 0x103: req_valid=%0b ins_valid=%0b", s_rv, s_iv);
    check("redir_req_valid", {31'b0, s_rv}, 32'h0);
    check("redir_ins_valid", {31'b0, s_iv}, 32'h0);
    step(1, 1, 1, 0, 0, 4);
    $display("after redirect: req_valid=%0b addr=%h", s_rv, s_addr);
    check("redir_first_req_valid", {31'b0, s_rv}, 32'h1);
    check("redir_first_req_addr", s_addr, 32'h100);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step(1, 1, 1, 0, 0, 4);
      if (s_iv) begin
        seen = 1'b1;
        $display("first decode after redirect: pc=%h", s_pc);
        check("redir_first_ins_pc", s_pc, 32'h100);
      end
    end
    check("redir_ins_seen", {31'b0, seen}, 32'h1);

    // Randomized traffic, occasional redirects and mid-stream resets.
    step(0, 1, 1, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 299) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      step(rst, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), redir, rpc,
           $urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
